// File: rtl/wb_sel_sequencer.sv
// Write-back controller for the 6:1 register-file write mux.
// Decodes the RV32I opcode into mux select, write enable and destination register, and
// sequences multi-cycle loads by stalling the PC until the data memory answers.
//
// Optional feature: define WB_TIMEOUT_EN to abort loads that wait TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   instr_valid    opcode/rd valid this cycle
//   opcode, rd     instr[6:0], instr[11:7]
//   mem_rd_ready   data memory read data valid
//   wb_sel         mux select: 000 ALU, 001 MEM, 010 PC+4, 011 IMM, 100 PC+IMM, 101 ZERO
//   reg_write      register file write enable
//   wb_rd          destination register for the write
//   mem_rd_req     data memory read request
//   pc_stall       hold PC / instruction this cycle
//   illegal_op     unsupported opcode while instr_valid
//   load_err       1-cycle pulse on load timeout
//   wait_cnt       wait cycles of the current/last load (saturating)
module wb_sel_sequencer #(
  parameter int unsigned SEL_W          = 3,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic             mem_rd_ready,
  output logic [SEL_W-1:0] wb_sel,
  output logic             reg_write,
  output logic [4:0]       wb_rd,
  output logic             mem_rd_req,
  output logic             pc_stall,
  output logic             illegal_op,
  output logic             load_err,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpLoad   = 7'b0000011;

  localparam logic [SEL_W-1:0] SelAlu   = SEL_W'(3'b000);
  localparam logic [SEL_W-1:0] SelMem   = SEL_W'(3'b001);
  localparam logic [SEL_W-1:0] SelPc4   = SEL_W'(3'b010);
  localparam logic [SEL_W-1:0] SelImm   = SEL_W'(3'b011);
  localparam logic [SEL_W-1:0] SelPcImm = SEL_W'(3'b100);
  localparam logic [SEL_W-1:0] SelZero  = SEL_W'(3'b101);

  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [0:0] {StIdle, StLdWait} state_e;

  state_e           state_q, state_d;
  logic [4:0]       rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_intent;
  logic             timeout;

`ifdef WB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
  assign timeout = (cnt_q == TimeoutLast);
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign wait_cnt = cnt_q;

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    wb_sel     = SelZero;
    wr_intent  = 1'b0;
    wb_rd      = rd;
    mem_rd_req = 1'b0;
    pc_stall   = 1'b0;
    illegal_op = 1'b0;
    load_err   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          unique case (opcode)
            OpReg, OpImm: begin
              wb_sel    = SelAlu;
              wr_intent = 1'b1;
            end
            OpJal, OpJalr: begin
              wb_sel    = SelPc4;
              wr_intent = 1'b1;
            end
            OpLui: begin
              wb_sel    = SelImm;
              wr_intent = 1'b1;
            end
            OpAuipc: begin
              wb_sel    = SelPcImm;
              wr_intent = 1'b1;
            end
            OpStore, OpBranch, OpSystem: begin
              wb_sel = SelZero;
            end
            OpLoad: begin
              // Ready is not looked at here, so every load spends at least one LD_WAIT cycle.
              mem_rd_req = 1'b1;
              pc_stall   = 1'b1;
              rd_d       = rd;
              cnt_d      = '0;
              state_d    = StLdWait;
            end
            default: illegal_op = 1'b1;
          endcase
        end
      end
      StLdWait: begin
        wb_sel     = SelMem;
        mem_rd_req = 1'b1;
        wb_rd      = rd_q;
        if (mem_rd_ready) begin
          // Data arriving in the timeout cycle still completes the load.
          wr_intent = 1'b1;
          state_d   = StIdle;
        end else begin
          pc_stall = 1'b1;
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
          if (timeout) begin
            load_err = 1'b1;
            pc_stall = 1'b0;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Writes to x0 are dropped, including load results.
    reg_write = wr_intent && (wb_rd != 5'd0);

    // Reset kills any in-flight load, including a same-cycle ready.
    if (rst) begin
      wb_sel     = SelZero;
      reg_write  = 1'b0;
      wb_rd      = 5'd0;
      mem_rd_req = 1'b0;
      pc_stall   = 1'b0;
      illegal_op = 1'b0;
      load_err   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rd_q    <= 5'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
